// File: rtl/adc_spi_responder.sv
// SPI responder that models an 8-channel 12-bit serial ADC, with all SPI pins oversampled on iCLK.
// Optional build macro ADC_RESP_RAMP_EN swaps iDATA for a {channel, frame count} ramp pattern.
`timescale 1ns/1ps
module adc_spi_responder #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCS_n,
  input  logic              iSCLK,
  input  logic              iDIN,
  input  logic [12*NCH-1:0] iDATA,
  output logic              oDOUT,
  output logic [2:0]        oCH,
  output logic              oBUSY,
  output logic              oFRAME_DONE
);

  logic [SYNC_STAGES-1:0] csSync_q, sclkSync_q, dinSync_q;
  logic                   csPrev_q, sclkPrev_q;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [2:0]             curCh_q, curCh_d;
  logic [2:0]             nextCh_q, nextCh_d;
  logic [15:0]            shift_q, shift_d;
  logic                   busy_q, frameDone_q, frameDone_d;

  logic       csCur, sclkCur, dinCur;
  logic       csFall, csRise, sclkRise, sclkFall;
  logic       frameEnd;
  logic [2:0] loadCh;
  logic [11:0] loadSample;

  // CS idles high through the synchronizer so a CS low at reset release reads as a fresh fall.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      csSync_q   <= '1;
      sclkSync_q <= '0;
      dinSync_q  <= '0;
      csPrev_q   <= 1'b1;
      sclkPrev_q <= 1'b0;
    end else begin
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], iCS_n};
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], iSCLK};
      dinSync_q  <= {dinSync_q[SYNC_STAGES-2:0], iDIN};
      csPrev_q   <= csSync_q[SYNC_STAGES-1];
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
    end
  end

  assign csCur    = csSync_q[SYNC_STAGES-1];
  assign sclkCur  = sclkSync_q[SYNC_STAGES-1];
  assign dinCur   = dinSync_q[SYNC_STAGES-1];
  assign csFall   = csPrev_q & ~csCur;
  assign csRise   = ~csPrev_q & csCur;
  assign sclkRise = ~sclkPrev_q & sclkCur;
  assign sclkFall = sclkPrev_q & ~sclkCur;
  assign frameEnd = ~csCur & ~csFall & sclkRise & (bitCnt_q == 4'd15);
  assign loadCh   = frameEnd ? nextCh_q : 3'd0;

`ifdef ADC_RESP_RAMP_EN
  logic [8:0] frameCnt_q, frameCnt_d;
  logic       unusedData;

  assign unusedData = ^iDATA;
  assign frameCnt_d = frameCnt_q + {8'd0, frameEnd};
  assign loadSample = {loadCh, frameCnt_d};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) frameCnt_q <= '0;
    else      frameCnt_q <= frameCnt_d;
  end
`else
  assign loadSample = iDATA[12*loadCh +: 12];
`endif

  // CS edges take priority; the fall at bitCnt 0 is the one before bit 0 and must not shift.
  always_comb begin
    bitCnt_d    = bitCnt_q;
    curCh_d     = curCh_q;
    nextCh_d    = nextCh_q;
    shift_d     = shift_q;
    frameDone_d = 1'b0;
    if (csRise) begin
      bitCnt_d = '0;
      curCh_d  = '0;
      nextCh_d = '0;
      shift_d  = '0;
    end else if (csFall) begin
      bitCnt_d = '0;
      curCh_d  = '0;
      nextCh_d = '0;
      shift_d  = {4'b0, loadSample};
    end else if (!csCur) begin
      if (sclkRise) begin
        case (bitCnt_q)
          4'd2:    nextCh_d[2] = dinCur;
          4'd3:    nextCh_d[1] = dinCur;
          4'd4:    nextCh_d[0] = dinCur;
          default: nextCh_d    = nextCh_q;
        endcase
        bitCnt_d = bitCnt_q + 4'd1;
        if (bitCnt_q == 4'd15) begin
          frameDone_d = 1'b1;
          curCh_d     = nextCh_q;
          shift_d     = {4'b0, loadSample};
        end
      end else if (sclkFall && bitCnt_q != 4'd0) begin
        shift_d = {shift_q[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bitCnt_q    <= '0;
      curCh_q     <= '0;
      nextCh_q    <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      bitCnt_q    <= bitCnt_d;
      curCh_q     <= curCh_d;
      nextCh_q    <= nextCh_d;
      shift_q     <= shift_d;
      busy_q      <= ~csCur;
      frameDone_q <= frameDone_d;
    end
  end

  assign oDOUT       = shift_q[15];
  assign oCH         = curCh_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = frameDone_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized scoreboard bench for adc_spi_responder: an SPI master drives frames while a
// frame-level model predicts each 16-bit word and next channel; a monitor checks on oFRAME_DONE.
`timescale 1ns/1ps
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst, csN, sclk, din;
  logic [95:0] data;
  logic        dout;
  logic [2:0]  ch;
  logic        busy, done;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] expWordQ[$];
  logic [2:0]  expChQ[$];
  logic [2:0]  modelCh;
  int          modelFrames;
  logic [15:0] rxWord = '0;
  logic        prevDone = 1'b0;

  always #5 clk = ~clk;

  adc_spi_responder #(.NCH(8), .SYNC_STAGES(2)) dut (
    .iCLK(clk), .iRST(rst), .iCS_n(csN), .iSCLK(sclk), .iDIN(din), .iDATA(data),
    .oDOUT(dout), .oCH(ch), .oBUSY(busy), .oFRAME_DONE(done)
  );

  // What the converter should return for channel c at the moment a frame's data is latched.
  function automatic logic [11:0] modelSample(input logic [2:0] c);
`ifdef ADC_RESP_RAMP_EN
    logic [8:0] cnt;
    cnt = 9'(modelFrames % 512);
    return {c, cnt};
`else
    return data[12*c +: 12];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Master-side receiver: samples the responder's data line on every SCLK rise inside a frame.
  always @(posedge sclk) begin
    if (csN === 1'b0) rxWord <= {rxWord[14:0], dout};
  end

  // Monitor: each completed frame is checked against the oldest outstanding prediction.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checkOutput("donePulseWidth", 32'(prevDone), 32'd0);
      if (expWordQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        checkOutput("frameWord", 32'(rxWord), 32'(expWordQ.pop_front()));
        checkOutput("frameCh", 32'(ch), 32'(expChQ.pop_front()));
      end
    end
    prevDone <= done;
  end

  task automatic csLow();
    @(negedge clk);
    csN = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic csHigh();
    @(negedge clk);
    csN     = 1'b1;
    modelCh = 3'd0;
    repeat (8) @(negedge clk);
  endtask

  // Drives nBits SCLK periods of one frame; a short frame is an abort and predicts nothing.
  task automatic applyStimulus(input logic [2:0] addr, input int nBits,
                               input logic doChange, input logic [95:0] newData);
    logic [15:0] dinWord;
    if (nBits == 16) begin
      expWordQ.push_back({4'b0, modelSample(modelCh)});
      expChQ.push_back(addr);
    end
    dinWord        = 16'($urandom);
    dinWord[13:11] = addr;
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      sclk = 1'b0;
      din  = dinWord[15-i];
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      if (i == 8 && doChange) data = newData;
      repeat (8) @(negedge clk);
    end
    if (nBits == 16) begin
      modelCh = addr;
      modelFrames++;
    end
  endtask

  initial begin
    logic [95:0] nd;
    int          nFrames;
    rst = 1'b1; csN = 1'b1; sclk = 1'b1; din = 1'b0; data = '0;
    modelCh = 3'd0; modelFrames = 0;

    for (int k = 0; k < 4; k++) begin
      csN = ~csN;
      repeat (5) @(negedge clk);
      checkOutput("resetDout", 32'(dout), 32'd0);
      checkOutput("resetCh", 32'(ch), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
    end
    csN = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    $display("[TB] directed frames");

    // Three frames addressing 2,2,0 right after reset (ramp build: 000, 401, 402).
    csLow();
    applyStimulus(3'd2, 16, 1'b0, data);
    applyStimulus(3'd2, 16, 1'b0, data);
    applyStimulus(3'd0, 16, 1'b0, data);
    csHigh();

    data[11:0] = 12'hABC; data[23:12] = 12'h123; data[71:60] = 12'h7F0;
    csLow();
    checkOutput("busyInFrame", 32'(busy), 32'd1);
    checkOutput("firstBitZero", 32'(dout), 32'd0);
    applyStimulus(3'd1, 16, 1'b0, data);
    csHigh();

    csLow();
    applyStimulus(3'd1, 16, 1'b0, data);
    applyStimulus(3'd5, 16, 1'b0, data);
    applyStimulus(3'd0, 16, 1'b0, data);
    csHigh();

    csLow();
    applyStimulus(3'd3, 9, 1'b0, data);
    csHigh();
    checkOutput("abortDout", 32'(dout), 32'd0);
    checkOutput("abortCh", 32'(ch), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    csLow();
    applyStimulus(3'd0, 16, 1'b0, data);
    csHigh();

    nd = data; nd[11:0] = 12'h555;
    csLow();
    applyStimulus(3'd0, 16, 1'b1, nd);
    applyStimulus(3'd0, 16, 1'b0, data);
    csHigh();

    $display("[TB] random frames");
    for (int g = 0; g < 12; g++) begin
      nFrames = $urandom_range(1, 3);
      csLow();
      for (int f = 0; f < nFrames; f++) begin
        nd = {$urandom, $urandom, $urandom};
        if (f == nFrames - 1 && $urandom_range(0, 5) == 0)
          applyStimulus(3'($urandom), $urandom_range(1, 15), 1'b1, nd);
        else
          applyStimulus(3'($urandom), 16, 1'($urandom_range(0, 1)), nd);
      end
      csHigh();
    end

    for (int k = 0; k < 100 && expWordQ.size() > 0; k++) @(negedge clk);
    checkOutput("drainQueue", 32'(expWordQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
